ram_loader: RTL and testbench

Upstream feeder for the 16K x 16 data RAM. It accepts a byte stream from the host link (UART receiver or test harness). It assembles each pair of bytes into a 16-bit word, big-endian, and writes the words into consecutive RAM addresses starting at a programmed base. This is how program and data images are bootstrapped into RAM before the CPU is released.

---
 rtl/ram_loader.sv | 187 ++++++++++++++++++
 tb/tb_ram_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// ram_loader -- byte-stream to 16-bit word RAM loader.
//
// Takes a host byte stream, packs each pair of bytes big-endian into a
// 16-bit word, and writes the words to consecutive RAM addresses starting
// at a base captured on an accepted start. Addresses wrap modulo 2^ADDR_W.
//
// Build option: define LOADER_CHECKSUM_EN to add a trailing checksum byte.
// That byte is compared against the modulo-256 sum of all data bytes in
// the load, and a mismatch sets the sticky error flag. When the macro is
// undefined, error is tied low and no sum logic exists.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        synchronous active-low reset
//   start        load request, honoured only in IDLE
//   base_addr    first RAM address, captured on accepted start
//   word_count   number of words to load, captured on accepted start
//   byte_valid   byte_data is valid
//   byte_data    incoming byte
//   byte_ready   loader accepts a byte this cycle
//   ram_load     RAM write enable (WRITE state only)
//   ram_address  RAM address, held between writes
//   ram_in       RAM write data, held between writes
//   busy         high in HI/LO/WRITE/CHK
//   done         one-cycle pulse at end of load
//   error        sticky checksum mismatch flag
module ram_loader #(
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  output logic [15:0]       ram_in,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HI,
    S_LO,
    S_WRITE,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cnt;
  logic [7:0]        hi;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       error_q;
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  // Write strobe is decoded from state. Address and data are registered
  // on the low-byte transfer, so they hold their values after the write.
  assign ram_load = (state == S_WRITE);

  always_comb begin
    state_n    = state;
    byte_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (word_count == '0) begin
`ifdef LOADER_CHECKSUM_EN
            state_n = S_CHK;
`else
            state_n = S_DONE;
`endif
          end else begin
            state_n = S_HI;
          end
        end
      end
      S_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_n = S_LO;
      end
      S_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_n = S_WRITE;
      end
      S_WRITE: begin
        busy = 1'b1;
        if (cnt == CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
          state_n = S_CHK;
`else
          state_n = S_DONE;
`endif
        end else begin
          state_n = S_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_n = S_DONE;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      addr        <= '0;
      cnt         <= '0;
      hi          <= '0;
      ram_address <= '0;
      ram_in      <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum         <= '0;
      error_q     <= 1'b0;
`endif
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr <= base_addr;
            cnt  <= word_count;
`ifdef LOADER_CHECKSUM_EN
            sum     <= '0;
            error_q <= 1'b0;
`endif
          end
        end
        S_HI: begin
          if (byte_valid) begin
            hi <= byte_data;
`ifdef LOADER_CHECKSUM_EN
            sum <= sum + byte_data;
`endif
          end
        end
        S_LO: begin
          if (byte_valid) begin
            ram_address <= addr;
            ram_in      <= {hi, byte_data};
`ifdef LOADER_CHECKSUM_EN
            sum <= sum + byte_data;
`endif
          end
        end
        S_WRITE: begin
          addr <= addr + ADDR_W'(1);
          cnt  <= cnt - CNT_W'(1);
        end
`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (byte_valid && (byte_data != sum)) error_q <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader -- directed, table-driven bench for ram_loader.
// Each table entry describes one load (base, count, byte stream, gap
// pattern) and the expected writes, done timing and error flag. Reset
// behaviour and mid-load reset are checked by hand-written sequences.
module tb_ram_loader;

`ifdef LOADER_CHECKSUM_EN
  localparam bit CK = 1'b1;
  localparam int NV = 6;
`else
  localparam bit CK = 1'b0;
  localparam int NV = 5;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [13:0] base_addr;
  logic [14:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        ram_load;
  logic [13:0] ram_address;
  logic [15:0] ram_in;
  logic        busy;
  logic        done;
  logic        error;

  always #5 clk = ~clk;

  ram_loader #(.ADDR_W(14), .CNT_W(15)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .word_count(word_count), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .ram_load(ram_load), .ram_address(ram_address),
    .ram_in(ram_in), .busy(busy), .done(done), .error(error)
  );

  typedef struct {
    logic [13:0]      base;
    logic [14:0]      cnt;
    logic [4:0][7:0]  b;      // b[0] is sent first
    int               nb;
    int               maxgap;
    bit               poke;   // pulse a conflicting start mid-load
    int               nwr;
    logic [1:0][13:0] a;
    logic [1:0][15:0] d;
    int               first;  // cycle of first ram_load, -1 = unchecked
    int               dcyc;   // cycle of done, -1 = unchecked
    bit               err;
  } vec_t;

  vec_t vt[NV];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [13:0] base, input logic [14:0] cnt,
                         input logic [39:0] b, input int nb, input int maxgap, input bit poke,
                         input int nwr, input logic [13:0] a0, input logic [15:0] d0,
                         input logic [13:0] a1, input logic [15:0] d1,
                         input int first, input int dcyc, input bit err);
    vt[i].base = base; vt[i].cnt = cnt; vt[i].b = b; vt[i].nb = nb;
    vt[i].maxgap = maxgap; vt[i].poke = poke; vt[i].nwr = nwr;
    vt[i].a[0] = a0; vt[i].d[0] = d0; vt[i].a[1] = a1; vt[i].d[1] = d1;
    vt[i].first = first; vt[i].dcyc = dcyc; vt[i].err = err;
  endtask

  // Cycle numbering: cycle 0 is the first negedge after the edge that
  // accepted start.
  task automatic run_vec(input int v);
    vec_t        t;
    int          idx, gap, cyc, nwr, first, dcyc;
    bit          wx;
    logic [13:0] wa[4];
    logic [15:0] wd[4];
    t = vt[v];
    @(negedge clk);
    base_addr = t.base; word_count = t.cnt; start = 1'b1; byte_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    idx = 0; gap = 0; cyc = 0; nwr = 0; first = -1; dcyc = -1; wx = 1'b0;
    check($sformatf("v%0d busy_c0", v), busy, (t.cnt != 0 || CK) ? 1 : 0);
    while (dcyc < 0 && cyc < 300) begin
      if (wx) begin
        idx++;
        gap = (t.maxgap > 0) ? int'($urandom_range(0, t.maxgap)) : 0;
      end
      if (ram_load) begin
        if (nwr < 4) begin wa[nwr] = ram_address; wd[nwr] = ram_in; end
        nwr++;
        if (first < 0) first = cyc;
      end
      if (done) begin
        dcyc = cyc;
        check($sformatf("v%0d busy_in_done", v), busy, 0);
      end
      start = t.poke && (cyc == 1);
      base_addr = 14'h2000; word_count = 15'd5;
      if (idx < t.nb && gap == 0) begin
        byte_valid = 1'b1; byte_data = t.b[idx];
      end else begin
        byte_valid = 1'b0; byte_data = 8'hEE;
        if (gap > 0) gap--;
      end
      wx = byte_valid && byte_ready;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0; byte_valid = 1'b0;
    if (dcyc < 0) begin
      vectors++; miscompares++;
      $display("FAIL v%0d timeout: no done within %0d cycles", v, cyc);
    end
    check($sformatf("v%0d done_after", v), done, 0);
    check($sformatf("v%0d busy_after", v), busy, 0);
    check($sformatf("v%0d nwr", v), nwr, t.nwr);
    for (int i = 0; i < t.nwr && i < 2 && i < nwr; i++) begin
      check($sformatf("v%0d addr%0d", v, i), wa[i], t.a[i]);
      check($sformatf("v%0d data%0d", v, i), wd[i], t.d[i]);
    end
    check($sformatf("v%0d bytes_used", v), idx, t.nb);
    if (t.first >= 0) check($sformatf("v%0d first_load", v), first, t.first);
    if (t.dcyc >= 0) check($sformatf("v%0d done_cyc", v), dcyc, t.dcyc);
    check($sformatf("v%0d error", v), error, t.err);
  endtask

  initial begin
    int k;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
    byte_valid = 1'b1; byte_data = 8'h55;

    // Checksum of 12 34 AB CD is 0xBE; 00 01 00 02 -> 0x03; 5A A5 -> 0xFF.
    set_vec(0, 14'h0010, 15'd2, 40'hBE_CD_AB_34_12, 4 + CK, 0, 1'b0, 2,
            14'h0010, 16'h1234, 14'h0011, 16'hABCD, 2, CK ? 7 : 6, 1'b0);
    set_vec(1, 14'h3FFF, 15'd2, 40'h03_02_00_01_00, 4 + CK, 0, 1'b0, 2,
            14'h3FFF, 16'h0001, 14'h0000, 16'h0002, 2, CK ? 7 : 6, 1'b0);
    set_vec(2, 14'h0010, 15'd2, 40'hBE_CD_AB_34_12, 4 + CK, 5, 1'b0, 2,
            14'h0010, 16'h1234, 14'h0011, 16'hABCD, -1, -1, 1'b0);
    set_vec(3, 14'h0123, 15'd0, 40'h00_00_00_00_00, CK ? 1 : 0, 0, 1'b0, 0,
            14'h0, 16'h0, 14'h0, 16'h0, -1, CK ? 1 : 0, 1'b0);
    set_vec(4, 14'h0100, 15'd1, 40'h00_00_FF_A5_5A, 2 + CK, 0, 1'b1, 1,
            14'h0100, 16'h5AA5, 14'h0, 16'h0, 2, CK ? 4 : 3, 1'b0);
`ifdef LOADER_CHECKSUM_EN
    set_vec(5, 14'h0010, 15'd2, 40'hBF_CD_AB_34_12, 5, 0, 1'b0, 2,
            14'h0010, 16'h1234, 14'h0011, 16'hABCD, 2, 7, 1'b1);
`endif

    // Reset state, with byte_valid high to show nothing is accepted.
    repeat (3) @(negedge clk);
    check("rst byte_ready", byte_ready, 0);
    check("rst ram_load", ram_load, 0);
    check("rst ram_address", ram_address, 0);
    check("rst ram_in", ram_in, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst error", error, 0);
    rst_n = 1'b1; byte_valid = 1'b0;

    for (int v = 0; v < NV; v++) run_vec(v);
    // A clean load after any error-setting one must clear error.
    run_vec(0);

    // Reset after the first word has been written.
    @(negedge clk);
    base_addr = 14'h0020; word_count = 15'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0; byte_valid = 1'b1; byte_data = 8'h77;
    k = 0;
    while (!ram_load && k < 20) begin @(negedge clk); k++; end
    check("mid write_seen", ram_load, 1);
    check("mid write_addr", ram_address, 14'h0020);
    check("mid write_data", ram_in, 16'h7777);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid rst ram_load", ram_load, 0);
    check("mid rst ram_address", ram_address, 0);
    check("mid rst ram_in", ram_in, 0);
    check("mid rst busy", busy, 0);
    check("mid rst byte_ready", byte_ready, 0);
    check("mid rst done", done, 0);
    check("mid rst error", error, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("post rst idle%0d ram_load", i), ram_load, 0);
      check($sformatf("post rst idle%0d byte_ready", i), byte_ready, 0);
    end
    byte_valid = 1'b0;
    run_vec(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
